// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - state encoding, colour-bar palette and line timing shared by the DVP source
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_V_BACK,
        ST_ACTIVE,
        ST_V_FRONT
    } dvp_state_t;

    // RGB565 bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [15:0] BAR_RGB [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    function automatic int line_len(input int width, input int h_blank);
        return 2 * width + h_blank;
    endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// rtl/dvp_tx_timing.sv - frame state machine with byte and line counters for the DVP source
module dvp_tx_timing #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720,
    parameter int H_BLANK      = 256,
    parameter int VSYNC_LINES  = 4,
    parameter int V_BACK       = 16,
    parameter int V_FRONT      = 4,
    localparam int XW          = $clog2(IMAGE_WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          active,
    output logic          vsync,
    output logic          byte_phase,
    output logic [XW-1:0] pixel_x,
    output logic          frame_start,
    output logic          frame_done
);
    import dvp_pkg::*;

    localparam int LL = line_len(IMAGE_WIDTH, H_BLANK);
    localparam int HW = $clog2(LL);

    dvp_state_t    state;
    logic [HW-1:0] h_cnt;
    logic [15:0]   v_cnt;
    logic [15:0]   v_last;
    logic          line_end;
    logic          block_end;

    always_comb begin
        v_last = '0;
        case (state)
            ST_VSYNC:   v_last = 16'(VSYNC_LINES - 1);
            ST_V_BACK:  v_last = 16'(V_BACK - 1);
            ST_ACTIVE:  v_last = 16'(IMAGE_HEIGHT - 1);
            ST_V_FRONT: v_last = 16'(V_FRONT - 1);
            default:    v_last = '0;
        endcase
    end

    assign line_end    = (h_cnt == HW'(LL - 1));
    assign block_end   = line_end && (v_cnt == v_last);
    assign frame_done  = (state == ST_V_FRONT) && block_end;
    assign frame_start = en && ((state == ST_IDLE) || frame_done);
    assign active      = (state == ST_ACTIVE) && (h_cnt < HW'(2 * IMAGE_WIDTH));
    assign vsync       = (state == ST_VSYNC);
    assign byte_phase  = h_cnt[0];
    assign pixel_x     = h_cnt[XW:1];

    // Every non-idle interval is a whole number of line periods, so one pair of counters serves all states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == ST_IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
            if (en)
                state <= ST_VSYNC;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + 1'b1;
            if (line_end)
                v_cnt <= block_end ? '0 : v_cnt + 1'b1;
            if (block_end) begin
                case (state)
                    ST_VSYNC:   state <= ST_V_BACK;
                    ST_V_BACK:  state <= ST_ACTIVE;
                    ST_ACTIVE:  state <= ST_V_FRONT;
                    ST_V_FRONT: state <= en ? ST_VSYNC : ST_IDLE;
                    default:    state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/dvp_tx.sv
// rtl/dvp_tx.sv - OV5640-style RGB565 DVP source fed by a pixel stream or internal colour bars
module dvp_tx #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720,
    parameter int H_BLANK      = 256,
    parameter int VSYNC_LINES  = 4,
    parameter int V_BACK       = 16,
    parameter int V_FRONT      = 4
) (
    input  logic        Clk,
    input  logic        Rst_p,
    input  logic        En,
    input  logic        Pattern_En,
    input  logic [15:0] Pix_Data,
    input  logic        Pix_Valid,
    output logic        Pix_Ready,
    output logic        Dvp_Vsync,
    output logic        Dvp_Href,
    output logic [7:0]  Dvp_Data,
    output logic        Underflow,
    output logic [15:0] Frame_Cnt
);
    import dvp_pkg::*;

    localparam int XW   = $clog2(IMAGE_WIDTH);
    localparam int BARW = IMAGE_WIDTH / 8;
    localparam int BW   = (BARW > 1) ? $clog2(BARW) : 1;

    logic          active, vsync, byte_phase, frame_start, frame_done;
    logic          frame_done_q, pattern_mode, fetch;
    logic [XW-1:0] pixel_x;
    logic [2:0]    bar_idx, base_idx;
    logic [BW-1:0] bar_pix, base_pix;
    logic [15:0]   pix_reg, cur_pix;

    dvp_tx_timing #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .clk        (Clk),
        .rst        (Rst_p),
        .en         (En),
        .active     (active),
        .vsync      (vsync),
        .byte_phase (byte_phase),
        .pixel_x    (pixel_x),
        .frame_start(frame_start),
        .frame_done (frame_done)
    );

    // The timing runs one cycle ahead of the pins, so a fetch here lands as the high byte next cycle.
    assign fetch     = active && !byte_phase;
    assign Pix_Ready = fetch && !pattern_mode;

    always_comb begin
        base_idx = (pixel_x == '0) ? 3'd0 : bar_idx;
        base_pix = (pixel_x == '0) ? '0 : bar_pix;
        if (pattern_mode)
            cur_pix = BAR_RGB[base_idx];
        else if (Pix_Valid)
            cur_pix = Pix_Data;
        else
            cur_pix = '0;
    end

    always_ff @(posedge Clk or posedge Rst_p) begin
        if (Rst_p) begin
            Dvp_Vsync    <= 1'b0;
            Dvp_Href     <= 1'b0;
            Dvp_Data     <= '0;
            Underflow    <= 1'b0;
            Frame_Cnt    <= '0;
            frame_done_q <= 1'b0;
            pattern_mode <= 1'b0;
            pix_reg      <= '0;
            bar_idx      <= '0;
            bar_pix      <= '0;
        end else begin
            Dvp_Vsync    <= vsync;
            Dvp_Href     <= active;
            frame_done_q <= frame_done;
            if (frame_start)
                pattern_mode <= Pattern_En;
            if (frame_done_q)
                Frame_Cnt <= Frame_Cnt + 1'b1;
            if (Pix_Ready && !Pix_Valid)
                Underflow <= 1'b1;
            if (!active) begin
                Dvp_Data <= '0;
            end else if (byte_phase) begin
                Dvp_Data <= pix_reg[7:0];
            end else begin
                Dvp_Data <= cur_pix[15:8];
                pix_reg  <= cur_pix;
                if (base_pix == BW'(BARW - 1)) begin
                    bar_idx <= base_idx + 3'd1;
                    bar_pix <= '0;
                end else begin
                    bar_idx <= base_idx;
                    bar_pix <= base_pix + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_tx.sv
// tb/tb_dvp_tx.sv - directed self-checking bench for dvp_tx on a small 8x3 frame
module tb_dvp_tx;

    localparam int W = 8, H = 3, HB = 6, VL = 1, VB = 2, VF = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pattern_en = 1'b0;
    logic [15:0] pix_data = 16'h0;
    logic        pix_valid = 1'b1;
    logic        pix_ready, vsync, href, underflow;
    logic [7:0]  data;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dvp_tx #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .H_BLANK(HB),
        .VSYNC_LINES(VL), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .Clk(clk), .Rst_p(rst), .En(en), .Pattern_En(pattern_en),
        .Pix_Data(pix_data), .Pix_Valid(pix_valid), .Pix_Ready(pix_ready),
        .Dvp_Vsync(vsync), .Dvp_Href(href), .Dvp_Data(data),
        .Underflow(underflow), .Frame_Cnt(frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] bar_line [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                  8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    int cyc = 0, vs_hi, href_hi, href_rises, t_vs_rise, t_vs_fall, t_href, t_fc;
    int ready_in_line, ready_idx, drop_idx = -1;
    int          ready_lines [$];
    logic [7:0]  bytes_q [$];
    logic [15:0] exp_pix [$];
    logic        vs_prev = 1'b0, href_prev = 1'b0;
    logic [15:0] fc_prev = 16'h0;

    always @(negedge clk) begin
        cyc++;
        check("excl", 32'(vsync & href), 0);
        if (!href) check("data_idle", 32'(data), 0);
        if (vsync) vs_hi++;
        if (vsync && !vs_prev) t_vs_rise = cyc;
        if (!vsync && vs_prev) t_vs_fall = cyc;
        if (href && !href_prev) begin
            href_rises++;
            if (t_href < 0) t_href = cyc;
        end
        if (href) begin
            href_hi++;
            bytes_q.push_back(data);
        end
        if (!href && href_prev) begin
            ready_lines.push_back(ready_in_line);
            ready_in_line = 0;
        end
        if (frame_cnt != fc_prev) t_fc = cyc;
        if (pix_ready) begin
            ready_in_line++;
            pix_data  = 16'h0100 + 16'(ready_idx);
            pix_valid = (ready_idx != drop_idx);
            exp_pix.push_back(pix_valid ? pix_data : 16'h0000);
            ready_idx++;
        end
        vs_prev = vsync;
        href_prev = href;
        fc_prev = frame_cnt;
    end

    task automatic clear_stats();
        vs_hi = 0; href_hi = 0; href_rises = 0;
        t_vs_rise = -1; t_vs_fall = -1; t_href = -1; t_fc = -1;
        ready_in_line = 0; ready_idx = 0;
        ready_lines.delete(); bytes_q.delete(); exp_pix.delete();
    endtask

    task automatic run_frame(input logic pat, input int drop, input bit late_drop);
        int n;
        @(posedge clk); #1;
        clear_stats();
        drop_idx = drop;
        pattern_en = pat;
        en = 1'b1;
        n = 0;
        while (!vsync && n < 10) begin @(negedge clk); n++; end
        check("vsync_start", 32'(vsync), 1);
        if (late_drop) begin
            n = 0;
            while (!href && n < 200) begin @(negedge clk); n++; end
            check("href_seen", 32'(href), 1);
        end
        en = 1'b0;
        n = 0;
        while (t_fc < 0 && n < 400) begin @(negedge clk); n++; end
        check("frame_end", 32'(t_fc >= 0), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame_shape();
        check("vsync_len", vs_hi, 22);
        check("vback_gap", t_href - t_vs_fall, 44);
        check("href_rises", href_rises, 3);
        check("href_cycles", href_hi, 48);
        check("frame_len", t_fc - t_vs_rise, 154);
    endtask

    task automatic check_bars();
        check("bar_ready", ready_idx, 0);
        for (int i = 0; i < 48; i++) check("bar_byte", 32'(bytes_q[i]), 32'(bar_line[i % 16]));
    endtask

    task automatic check_stream();
        logic [15:0] p;
        check("ready_lines_n", ready_lines.size(), 3);
        for (int l = 0; l < 3; l++) check("ready_per_line", ready_lines[l], 8);
        check("pix_n", exp_pix.size(), 24);
        for (int i = 0; i < 48; i++) begin
            p = exp_pix[i / 2];
            check("stream_byte", 32'(bytes_q[i]), (i % 2 == 1) ? 32'(p[7:0]) : 32'(p[15:8]));
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_vsync", 32'(vsync), 0);
        check("rst_href", 32'(href), 0);
        check("rst_data", 32'(data), 0);
        check("rst_ready", 32'(pix_ready), 0);
        check("rst_underflow", 32'(underflow), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_vsync", 32'(vsync), 0);

        // colour bars
        run_frame(1'b1, -1, 1'b0);
        check_frame_shape();
        check_bars();
        check("t1_frame_cnt", 32'(frame_cnt), 1);

        // stream, always valid
        run_frame(1'b0, -1, 1'b0);
        check_frame_shape();
        check_stream();
        check("t2_b0", 32'(bytes_q[0]), 32'h01);
        check("t2_b1", 32'(bytes_q[1]), 32'h00);
        check("t2_b2", 32'(bytes_q[2]), 32'h01);
        check("t2_b3", 32'(bytes_q[3]), 32'h01);
        check("t2_underflow", 32'(underflow), 0);
        check("t2_frame_cnt", 32'(frame_cnt), 2);

        // stream, third fetch of the second line starved
        run_frame(1'b0, 10, 1'b0);
        check_frame_shape();
        check_stream();
        check("t3_prev_hi", 32'(bytes_q[18]), 32'h01);
        check("t3_prev_lo", 32'(bytes_q[19]), 32'h09);
        check("t3_drop_hi", 32'(bytes_q[20]), 32'h00);
        check("t3_drop_lo", 32'(bytes_q[21]), 32'h00);
        check("t3_next_hi", 32'(bytes_q[22]), 32'h01);
        check("t3_next_lo", 32'(bytes_q[23]), 32'h0B);
        check("t3_underflow", 32'(underflow), 1);
        check("t3_frame_cnt", 32'(frame_cnt), 3);

        // En dropped during the first active line
        run_frame(1'b1, -1, 1'b1);
        check_frame_shape();
        check("t4_frame_cnt", 32'(frame_cnt), 4);
        repeat (30) @(negedge clk);
        check("t4_idle_vsync", 32'(vsync), 0);
        check("t4_idle_href", 32'(href), 0);
        check("t4_idle_data", 32'(data), 0);
        check("t4_frame_cnt_hold", 32'(frame_cnt), 4);
        check("t4_underflow_sticky", 32'(underflow), 1);

        // asynchronous reset while Href is high
        @(posedge clk); #1;
        clear_stats();
        drop_idx = -1;
        pattern_en = 1'b0;
        en = 1'b1;
        n = 0;
        while (!href && n < 200) begin @(negedge clk); n++; end
        check("t5_href_seen", 32'(href), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_vsync", 32'(vsync), 0);
        check("t5_href", 32'(href), 0);
        check("t5_data", 32'(data), 0);
        check("t5_ready", 32'(pix_ready), 0);
        check("t5_underflow", 32'(underflow), 0);
        check("t5_frame_cnt", 32'(frame_cnt), 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_frame(1'b1, -1, 1'b0);
        check_frame_shape();
        check_bars();
        check("t5_frame_cnt_after", 32'(frame_cnt), 1);

        // frame counter wrap
        @(negedge clk);
        force dut.Frame_Cnt = 16'hFFFF;
        @(negedge clk);
        release dut.Frame_Cnt;
        @(negedge clk);
        check("t6_forced", 32'(frame_cnt), 32'hFFFF);
        run_frame(1'b1, -1, 1'b0);
        check_frame_shape();
        check("t6_wrap", 32'(frame_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dvp_tx.md
Name: dvp_tx

Overview:
- DVP source that emulates an OV5640 running in RGB565 mode. It is the transmitting end of the DVP link our capture path receives.
- Produces Vsync, Href and 8-bit data from a 16-bit pixel stream, or from an internal colour-bar pattern.
- Used as a camera stand-in for bring-up and regression of the capture → DDR3 → HDMI chain.
- Lives in the camera clock domain. The integrator forwards an inverted copy of Clk as the DVP pixel clock.

Parameters:
- IMAGE_WIDTH, 1280: active pixels per line. Must be a multiple of 8.
- IMAGE_HEIGHT, 720: active lines per frame.
- H_BLANK, 256: Href-low cycles after each active line's bytes.
- VSYNC_LINES, 4: Vsync-high duration, in line periods.
- V_BACK, 16: blank lines between Vsync fall and the first active line.
- V_FRONT, 4: blank lines after the last active line.

Ports:
- Clk  in  1  byte clock; every output changes on its rising edge.
- Rst_p  in  1  asynchronous reset, active-high.
- En  in  1  frame enable; sampled only at frame boundaries.
- Pattern_En  in  1  1 = colour bars, 0 = pixel stream; sampled at frame start.
- Pix_Data  in  16  RGB565 input pixel.
- Pix_Valid  in  1  Pix_Data is valid.
- Pix_Ready  out  1  the block is consuming a pixel this cycle.
- Dvp_Vsync  out  1  frame sync, active-high.
- Dvp_Href  out  1  line valid.
- Dvp_Data  out  8  byte lane; high byte of each pixel first.
- Underflow  out  1  sticky flag; cleared only by reset.
- Frame_Cnt  out  16  completed frames; wraps at 16'hFFFF→0.

Behaviour:
- Reset (asynchronous, Rst_p=1): all outputs 0, state IDLE, all counters 0.
- Line period: LINE_LEN = 2*IMAGE_WIDTH + H_BLANK cycles. Every vertical interval is counted in line periods.
- State machine:
  - IDLE: outputs low. Goes to VSYNC when En=1. Pattern_En is latched on that transition.
  - VSYNC: Dvp_Vsync=1 for VSYNC_LINES*LINE_LEN cycles, then V_BACK.
  - V_BACK: V_BACK*LINE_LEN cycles, all outputs low, then ACTIVE.
  - ACTIVE: line counter 0..IMAGE_HEIGHT-1. Each line is:
    - Href=1 for 2*IMAGE_WIDTH cycles, bytes P[15:8], P[7:0] per pixel;
    - then H_BLANK cycles with Href=0 and Dvp_Data=0.
    - After the last line's blank, go to V_FRONT.
  - V_FRONT: V_FRONT*LINE_LEN cycles. On exit, Frame_Cnt increments. Go to VSYNC if En=1, else IDLE.
- Mid-frame En deassertion has no effect; the current frame always completes.
- Pixel fetch (stream mode):
  - Pix_Ready=1 for exactly one cycle, the cycle before each pixel's high byte: the last cycle before Href rises, then every low-byte cycle except the line's last.
  - The pixel is taken in that same cycle. Its high byte appears at t+1, its low byte at t+2.
  - Exactly IMAGE_WIDTH Pix_Ready pulses per line.
  - If Pix_Valid=0 in a Pix_Ready cycle, send 16'h0000 for that pixel and set Underflow. The next pixel is fetched normally.
- Pattern mode:
  - Pix_Ready stays 0.
  - 8 vertical bars, each IMAGE_WIDTH/8 pixels wide, tracked with a bar-pixel counter (no divider).
  - Bar colours, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Dvp_Data is 0 whenever Href=0.
- Dvp_Vsync and Dvp_Href are never high at the same time.

Decomposition:
- Shared package (dvp_pkg):
  - state encoding: IDLE, VSYNC, V_BACK, ACTIVE, V_FRONT;
  - the eight RGB565 bar constants;
  - the LINE_LEN function.
- One sub-module, dvp_tx_timing: line/byte/frame counters and the state machine, exporting active, byte_phase, pixel_x and frame_done.
- The top level adds the pixel mux, byte serializer and flags.

Test Plan:
All cases use WIDTH=8, HEIGHT=3, H_BLANK=6, VSYNC_LINES=1, V_BACK=2, V_FRONT=1, so LINE_LEN=22.
1. Reset, then En=1, Pattern_En=1, one frame:
   - Vsync high for 22 cycles; Href rises 44 cycles after Vsync falls.
   - Per line: 16 Href-high cycles, bytes FF FF FF E0 07 FF … 00 00.
   - Href rises 3 times; Frame_Cnt=1 after 22+44+66+22=154 cycles.
2. Stream mode, Pix_Valid always 1, Pix_Data=incrementing from 16'h0100:
   - Pix_Ready pulses 8 times per line.
   - First line bytes 01 00 01 01 …; Underflow stays 0.
3. Stream mode, Pix_Valid=0 at the 3rd Pix_Ready of line 2:
   - That pixel is sent as 00 00 and Underflow=1.
   - The next pixel is correct; the frame length is unchanged.
4. Drop En during line 1:
   - The frame completes and Frame_Cnt increments.
   - The block returns to IDLE with Vsync, Href and Data all 0.
5. Assert Rst_p mid-line with Href=1:
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release with En=1, the next Vsync starts a clean frame.
6. Force Frame_Cnt to 16'hFFFF, run one frame: Frame_Cnt=0.
   - Check Vsync/Href exclusivity and Data=0 when Href=0 on every cycle.
